// File: rtl/slink_pkg.sv
// Shared types for the serial-link PHY config path (TX sequencer and RX checker).
// The config struct is built by a macro so each user can size it with its own clk_div_t.
`ifndef SLINK_PKG_SV
`define SLINK_PKG_SV

`define SLINK_TYPEDEF_PHY_CFG_T(name_t, div_t) \
  typedef struct packed { \
    div_t clk_div; \
    div_t shift_start; \
    div_t shift_end; \
  } name_t;

package slink_pkg;
  typedef enum logic [2:0] {PASS, DRAIN, QUIET, APPLY, TRAIN} slink_cfg_state_e;

  localparam int unsigned QuietCntW = 8;

  // Default-width flavour for MaxClkDiv = 32.
  `SLINK_TYPEDEF_PHY_CFG_T(slink_phy_cfg_t, logic [5:0])
endpackage

`endif

// File: rtl/slink_phy_cfg_check.sv
// Combinational legality check of a requested divider/phase setting.
// Shared by the TX sequencer and the RX-side config path.
module slink_phy_cfg_check #(
  parameter int unsigned MaxClkDiv = 32,
  parameter bit          EnDdr     = 1'b1,
  parameter type         clk_div_t = logic [$clog2(MaxClkDiv):0]
) (
  input  clk_div_t i_clk_div,
  input  clk_div_t i_shift_start,
  input  clk_div_t i_shift_end,
  output logic     o_legal
);

  logic w_range, w_shift, w_ddr;

  assign w_range = (32'(i_clk_div) >= 32'd2) && (32'(i_clk_div) <= MaxClkDiv);
  assign w_shift = (i_shift_start < i_clk_div) && (i_shift_end < i_clk_div) &&
                   (i_shift_start != i_shift_end);
  // DDR launches on both edges, so an odd divider has no symmetric half period.
  assign w_ddr   = !(EnDdr && i_clk_div[0]);
  assign o_legal = w_range && w_shift && w_ddr;

endmodule

// File: rtl/slink_phy_cfg_ctrl.sv
// TX PHY runtime config sequencer: drain, park the clock for a quiet interval,
// apply the pending divider/phase setting, then send an optional training burst.
module slink_phy_cfg_ctrl import slink_pkg::*; #(
  parameter int unsigned NumLanes      = 8,
  parameter int unsigned MaxClkDiv     = 32,
  parameter bit          EnDdr         = 1'b1,
  parameter int unsigned DefClkDiv     = 8,
  parameter int unsigned DefShiftStart = 2,
  parameter int unsigned DefShiftEnd   = 6,
  parameter int unsigned QuietCycles   = 8,
  parameter int unsigned TrainBeats    = 4,
  parameter type         phy_data_t    = logic [NumLanes-1:0],
  parameter type         clk_div_t     = logic [$clog2(MaxClkDiv):0]
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  clk_div_t  cfg_clk_div_i,
  input  clk_div_t  cfg_shift_start_i,
  input  clk_div_t  cfg_shift_end_i,
  input  logic      cfg_valid_i,
  output logic      cfg_ready_o,
  output logic      cfg_err_o,
  input  phy_data_t train_pattern_i,
  input  phy_data_t data_i,
  input  logic      valid_i,
  output logic      ready_o,
  output phy_data_t phy_data_o,
  output logic      phy_valid_o,
  input  logic      phy_ready_i,
  output clk_div_t  phy_clk_div_o,
  output clk_div_t  phy_shift_start_o,
  output clk_div_t  phy_shift_end_o,
  output logic      busy_o
);

  `SLINK_TYPEDEF_PHY_CFG_T(cfg_t, clk_div_t)

  localparam int unsigned TrainW = (TrainBeats > 0) ? $clog2(TrainBeats + 1) : 1;
  localparam cfg_t DefCfg = '{clk_div:     clk_div_t'(DefClkDiv),
                              shift_start: clk_div_t'(DefShiftStart),
                              shift_end:   clk_div_t'(DefShiftEnd)};

  slink_cfg_state_e     r_state;
  cfg_t                 r_pend, r_act;
  logic [QuietCntW-1:0] r_quiet_cnt;
  logic [TrainW-1:0]    r_train_cnt;
  logic                 r_cfg_ready, r_cfg_err;
  logic                 w_legal;
  cfg_t                 w_req;

  assign w_req = '{clk_div: cfg_clk_div_i, shift_start: cfg_shift_start_i,
                   shift_end: cfg_shift_end_i};

  slink_phy_cfg_check #(
    .MaxClkDiv (MaxClkDiv),
    .EnDdr     (EnDdr),
    .clk_div_t (clk_div_t)
  ) u_check (
    .i_clk_div     (cfg_clk_div_i),
    .i_shift_start (cfg_shift_start_i),
    .i_shift_end   (cfg_shift_end_i),
    .o_legal       (w_legal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= PASS;
      r_pend      <= DefCfg;
      r_act       <= DefCfg;
      r_quiet_cnt <= '0;
      r_train_cnt <= '0;
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_ready <= 1'b0;
      r_cfg_err   <= 1'b0;
      case (r_state)
        // A request seen in its own ack cycle was already consumed.
        PASS: if (cfg_valid_i && !r_cfg_ready) begin
          if (w_legal) begin
            r_pend  <= w_req;
            r_state <= DRAIN;
          end else begin
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b1;
          end
        end
        DRAIN: if (!valid_i || phy_ready_i) begin
          r_quiet_cnt <= QuietCntW'(QuietCycles);
          r_state     <= QUIET;
        end
        QUIET: begin
          if (r_quiet_cnt <= QuietCntW'(1)) begin
            r_cfg_ready <= 1'b1;
            r_state     <= APPLY;
          end else begin
            r_quiet_cnt <= r_quiet_cnt - QuietCntW'(1);
          end
        end
        APPLY: begin
          r_act       <= r_pend;
          r_train_cnt <= TrainW'(TrainBeats);
          r_state     <= (TrainBeats > 0) ? TRAIN : PASS;
        end
        TRAIN: if (phy_ready_i) begin
          if (r_train_cnt <= TrainW'(1)) r_state <= PASS;
          else r_train_cnt <= r_train_cnt - TrainW'(1);
        end
        default: r_state <= PASS;
      endcase
    end
  end

  always_comb begin
    phy_data_o  = data_i;
    phy_valid_o = 1'b0;
    ready_o     = 1'b0;
    case (r_state)
      PASS, DRAIN: begin
        phy_valid_o = valid_i;
        ready_o     = phy_ready_i;
      end
      TRAIN: begin
        phy_data_o  = train_pattern_i;
        phy_valid_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_o            = (r_state != PASS);
  assign cfg_ready_o       = r_cfg_ready;
  assign cfg_err_o         = r_cfg_err;
  assign phy_clk_div_o     = r_act.clk_div;
  assign phy_shift_start_o = r_act.shift_start;
  assign phy_shift_end_o   = r_act.shift_end;

endmodule

// File: tb/tb_slink_phy_cfg_ctrl.sv
// Bench for slink_phy_cfg_ctrl: instance A trains 4 beats, instance B skips training.
`timescale 1ns/1ps
module tb_slink_phy_cfg_ctrl;
  typedef logic [5:0] div_t;
  typedef logic [7:0] dat_t;

  typedef struct {
    int cd, ss, se;
    bit err;
    int ack;
    int ecd, ess, ese;
  } vec_t;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  div_t cfg_cd, cfg_ss, cfg_se;
  logic cfg_valid, valid, phy_ready;
  dat_t train_pat, data;

  logic a_cfg_ready, a_cfg_err, a_ready, a_phy_valid, a_busy;
  logic b_cfg_ready, b_cfg_err, b_ready, b_phy_valid, b_busy;
  dat_t a_phy_data, b_phy_data;
  div_t a_cd, a_ss, a_se, b_cd, b_ss, b_se;

  int nvec = 0, nerr = 0;
  vec_t tbl[10];

  slink_phy_cfg_ctrl #(.TrainBeats(4)) u_a (
    .clk_i, .rst_ni,
    .cfg_clk_div_i(cfg_cd), .cfg_shift_start_i(cfg_ss), .cfg_shift_end_i(cfg_se),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(a_cfg_ready), .cfg_err_o(a_cfg_err),
    .train_pattern_i(train_pat), .data_i(data), .valid_i(valid), .ready_o(a_ready),
    .phy_data_o(a_phy_data), .phy_valid_o(a_phy_valid), .phy_ready_i(phy_ready),
    .phy_clk_div_o(a_cd), .phy_shift_start_o(a_ss), .phy_shift_end_o(a_se),
    .busy_o(a_busy));

  slink_phy_cfg_ctrl #(.TrainBeats(0)) u_b (
    .clk_i, .rst_ni,
    .cfg_clk_div_i(cfg_cd), .cfg_shift_start_i(cfg_ss), .cfg_shift_end_i(cfg_se),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(b_cfg_ready), .cfg_err_o(b_cfg_err),
    .train_pattern_i(train_pat), .data_i(data), .valid_i(valid), .ready_o(b_ready),
    .phy_data_o(b_phy_data), .phy_valid_o(b_phy_valid), .phy_ready_i(phy_ready),
    .phy_clk_div_o(b_cd), .phy_shift_start_o(b_ss), .phy_shift_end_o(b_se),
    .busy_o(b_busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int c, input int s, input int e);
    div_t dc, ds, de;
    dc = div_t'(c); ds = div_t'(s); de = div_t'(e);
    return {14'd0, dc, ds, de};
  endfunction

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0; cfg_valid = 1'b0; valid = 1'b0; phy_ready = 1'b0;
    tick; tick;
    rst_ni = 1'b1;
    tick;
  endtask

  task automatic set_req(input int c, input int s, input int e);
    cfg_cd = div_t'(c); cfg_ss = div_t'(s); cfg_se = div_t'(e); cfg_valid = 1'b1;
  endtask

  initial begin
    cfg_cd = '0; cfg_ss = '0; cfg_se = '0; cfg_valid = 1'b0;
    valid = 1'b0; phy_ready = 1'b0; data = '0; train_pat = 8'hA5;

    tbl[0] = '{4, 1, 3, 1'b0, 10, 4, 1, 3};
    tbl[1] = '{1, 0, 0, 1'b1, 1, 4, 1, 3};
    tbl[2] = '{6, 3, 3, 1'b1, 1, 4, 1, 3};
    tbl[3] = '{7, 1, 3, 1'b1, 1, 4, 1, 3};
    tbl[4] = '{64, 0, 1, 1'b1, 1, 4, 1, 3};
    tbl[5] = '{32, 0, 31, 1'b0, 10, 32, 0, 31};
    tbl[6] = '{34, 2, 4, 1'b1, 1, 32, 0, 31};
    tbl[7] = '{8, 8, 0, 1'b1, 1, 32, 0, 31};
    tbl[8] = '{2, 1, 0, 1'b0, 10, 2, 1, 0};
    tbl[9] = '{8, 0, 7, 1'b0, 10, 8, 0, 7};

    // Reset defaults and zero-latency passthrough.
    do_reset;
    chk("rst cfg", pk(a_cd, a_ss, a_se), pk(8, 2, 6));
    chk("rst cfg_ready", a_cfg_ready, 0);
    chk("rst cfg_err", a_cfg_err, 0);
    chk("rst busy", a_busy, 0);
    valid = 1'b1; data = 8'h5A; phy_ready = 1'b1; #1;
    chk("pass valid", a_phy_valid, 1);
    chk("pass data", a_phy_data, 8'h5A);
    chk("pass ready", a_ready, 1);
    phy_ready = 1'b0; #1;
    chk("pass ready low", a_ready, 0);
    valid = 1'b0; #1;
    chk("pass valid low", a_phy_valid, 0);
    tick;

    // Table of requests on an idle link; config carries over between entries.
    for (int i = 0; i < 10; i++) begin
      int ack_a, ack_b;
      bit err_a, busy_seen;
      ack_a = -1; ack_b = -1; err_a = 1'b0; busy_seen = 1'b0;
      set_req(tbl[i].cd, tbl[i].ss, tbl[i].se);
      valid = 1'b0; phy_ready = 1'b0;
      for (int k = 1; k <= 40 && ack_a < 0; k++) begin
        tick;
        if (a_busy) busy_seen = 1'b1;
        if (b_cfg_ready && ack_b < 0) ack_b = k;
        if (a_cfg_ready) begin
          ack_a = k; err_a = a_cfg_err; cfg_valid = 1'b0;
        end
      end
      chk($sformatf("v%0d ack cycle", i), ack_a, tbl[i].ack);
      chk($sformatf("v%0d err", i), err_a, tbl[i].err);
      chk($sformatf("v%0d B ack cycle", i), ack_b, tbl[i].ack);
      chk($sformatf("v%0d busy seen", i), busy_seen, !tbl[i].err);
      tick;
      chk($sformatf("v%0d cfg A", i), pk(a_cd, a_ss, a_se), pk(tbl[i].ecd, tbl[i].ess, tbl[i].ese));
      chk($sformatf("v%0d cfg B", i), pk(b_cd, b_ss, b_se), pk(tbl[i].ecd, tbl[i].ess, tbl[i].ese));
      chk($sformatf("v%0d no reack", i), a_cfg_ready, 0);
      if (!tbl[i].err) begin
        for (int b = 0; b < 4; b++) begin
          chk($sformatf("v%0d train%0d valid", i, b), a_phy_valid, 1);
          chk($sformatf("v%0d train%0d data", i, b), a_phy_data, 8'hA5);
          phy_ready = 1'b1; tick; phy_ready = 1'b0;
        end
        chk($sformatf("v%0d train done", i), a_busy, 0);
      end
    end

    // Request with a beat in flight: drain, quiet, apply, train, resume held beat.
    do_reset;
    valid = 1'b1; data = 8'hC3;
    set_req(8, 1, 5);
    tick;
    chk("fl drain busy", a_busy, 1);
    chk("fl drain valid", a_phy_valid, 1);
    chk("fl drain data", a_phy_data, 8'hC3);
    tick;
    chk("fl drain hold", a_phy_valid, 1);
    phy_ready = 1'b1; #1;
    chk("fl drain ready", a_ready, 1);
    tick;
    phy_ready = 1'b0; data = 8'h3C;
    for (int q = 0; q < 8; q++) begin
      #1;
      chk($sformatf("fl quiet%0d valid", q), a_phy_valid, 0);
      chk($sformatf("fl quiet%0d ready", q), a_ready, 0);
      chk($sformatf("fl quiet%0d noack", q), a_cfg_ready, 0);
      tick;
    end
    chk("fl apply ack", a_cfg_ready, 1);
    chk("fl apply err", a_cfg_err, 0);
    chk("fl apply valid", a_phy_valid, 0);
    chk("fl apply cfg old", pk(a_cd, a_ss, a_se), pk(8, 2, 6));
    cfg_valid = 1'b0;
    tick;
    chk("fl cfg new", pk(a_cd, a_ss, a_se), pk(8, 1, 5));
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("fl train%0d valid", b), a_phy_valid, 1);
      chk($sformatf("fl train%0d data", b), a_phy_data, 8'hA5);
      chk($sformatf("fl train%0d ready", b), a_ready, 0);
      phy_ready = 1'b1; tick; phy_ready = 1'b0;
      if (b < 3) begin
        chk($sformatf("fl gap%0d valid", b), a_phy_valid, 1);
        tick;
      end
    end
    chk("fl resume busy", a_busy, 0);
    chk("fl resume valid", a_phy_valid, 1);
    chk("fl resume data", a_phy_data, 8'h3C);
    valid = 1'b0;

    // Asynchronous reset during QUIET drops the pending request silently.
    do_reset;
    set_req(4, 1, 3);
    repeat (5) tick;
    chk("rq busy in quiet", a_busy, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rq cfg async", pk(a_cd, a_ss, a_se), pk(8, 2, 6));
    chk("rq busy async", a_busy, 0);
    cfg_valid = 1'b0;
    tick; tick;
    rst_ni = 1'b1;
    begin
      int acks;
      bit bsy;
      acks = 0; bsy = 1'b0;
      for (int k = 0; k < 15; k++) begin
        tick;
        if (a_cfg_ready) acks++;
        if (a_busy) bsy = 1'b1;
      end
      chk("rq no ack", acks, 0);
      chk("rq stays pass", bsy, 0);
    end

    // Back-to-back legal requests with cfg_valid held (no-training instance).
    do_reset;
    set_req(4, 1, 3);
    valid = 1'b0;
    begin
      int nack, c1, c2;
      bit anyerr;
      nack = 0; c1 = -1; c2 = -1; anyerr = 1'b0;
      for (int k = 1; k <= 60; k++) begin
        tick;
        if (b_cfg_ready) begin
          nack++;
          if (b_cfg_err) anyerr = 1'b1;
          if (nack == 1) begin c1 = k; set_req(6, 1, 5); end
          else begin c2 = k; cfg_valid = 1'b0; end
        end
      end
      chk("b2b ack count", nack, 2);
      chk("b2b first ack", c1, 10);
      chk("b2b second ack", c2, 21);
      chk("b2b err", anyerr, 0);
      chk("b2b final cfg", pk(b_cd, b_ss, b_se), pk(6, 1, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
